// File: rtl/bsg_dramsim3_ch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bsg_dramsim3_ch_arbiter
// Brief    : Round-robin arbiter that shares one dramsim3 channel port among
//            several requesters and routes read returns back to their owner
//            by address, oldest-first among equal addresses.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_dramsim3_ch_arbiter #(
   parameter int num_req_p            = 2,
   parameter int channel_addr_width_p = 32,
   parameter int data_width_p         = 256,
   parameter int max_out_p            = 8
) (
   input  logic                                            clk_i,
   input  logic                                            reset_n_i,
   input  logic [num_req_p-1:0]                            v_i,
   input  logic [num_req_p-1:0]                            write_not_read_i,
   input  logic [num_req_p-1:0][channel_addr_width_p-1:0]  ch_addr_i,
   output logic [num_req_p-1:0]                            yumi_o,
   output logic                                            v_o,
   output logic                                            write_not_read_o,
   output logic [channel_addr_width_p-1:0]                 ch_addr_o,
   input  logic                                            yumi_i,
   input  logic                                            data_v_i,
   input  logic [channel_addr_width_p-1:0]                 read_done_ch_addr_i,
   input  logic [data_width_p-1:0]                         data_i,
   output logic [num_req_p-1:0]                            data_v_o,
   output logic [data_width_p-1:0]                         data_o,
   output logic [$clog2(max_out_p):0]                      outstanding_o,
   output logic                                            error_o
);

   localparam int c_req_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int c_ent_w = $clog2(max_out_p);
   localparam int c_cnt_w = $clog2(max_out_p) + 1;
   localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(max_out_p);
   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_hold = 1'b1;

   logic [0:0]                      r_state;
   logic [c_req_w-1:0]              r_rr_ptr;
   logic [c_req_w-1:0]              r_hold_idx;
   logic [max_out_p-1:0]            r_ent_v;
   logic [channel_addr_width_p-1:0] r_ent_addr  [max_out_p];
   logic [c_req_w-1:0]              r_ent_owner [max_out_p];
   // Age rank: 0 is youngest; ranks stay dense so they never exceed max_out_p-1
   logic [c_ent_w-1:0]              r_ent_age   [max_out_p];
   logic [c_cnt_w-1:0]              r_count;

   logic                 w_full;
   logic [num_req_p-1:0] w_elig;
   logic                 w_any_elig;
   logic [c_req_w-1:0]   w_win_idx;
   logic [c_req_w-1:0]   w_cand;
   logic [c_req_w-1:0]   w_grant;
   logic [c_req_w-1:0]   w_rr_next;
   logic                 w_req_v;
   logic                 w_accept;
   logic                 w_alloc;
   logic [c_ent_w-1:0]   w_free_idx;
   logic                 w_ret;
   logic                 w_hit;
   logic [c_ent_w-1:0]   w_hit_idx;
   logic [c_ent_w-1:0]   w_hit_age;
   logic                 w_free;

   // Reads are only eligible against the registered occupancy
   assign w_full = (r_count == c_max_out);
   assign w_elig = v_i & (write_not_read_i | {num_req_p{~w_full}});

   // Round-robin search starting at the pointer, wrapping to requester 0
   always_comb begin
      w_any_elig = 1'b0;
      w_win_idx  = '0;
      w_cand     = '0;
      for (int k = 0; k < num_req_p; k++) begin
         w_cand = c_req_w'((int'(r_rr_ptr) + k) % num_req_p);
         if (!w_any_elig && w_elig[w_cand]) begin
            w_any_elig = 1'b1;
            w_win_idx  = w_cand;
         end
      end
   end

   // While holding, the latched requester owns the port regardless of others
   assign w_grant          = (r_state == c_st_hold) ? r_hold_idx : w_win_idx;
   assign w_req_v          = reset_n_i & ((r_state == c_st_hold) | w_any_elig);
   assign w_accept         = w_req_v & yumi_i;
   assign w_alloc          = w_accept & ~write_not_read_o;
   assign w_rr_next        = c_req_w'((int'(w_grant) + 1) % num_req_p);
   assign v_o              = w_req_v;
   assign write_not_read_o = write_not_read_i[w_grant];
   assign ch_addr_o        = ch_addr_i[w_grant];

   // Consume strobe goes only to the granted requester
   always_comb begin
      yumi_o = '0;
      if (w_accept) begin
         yumi_o[w_grant] = 1'b1;
      end
   end

   // Lowest-index free entry, judged on registered validity only
   always_comb begin
      w_free_idx = '0;
      for (int j = max_out_p - 1; j >= 0; j--) begin
         if (!r_ent_v[j]) begin
            w_free_idx = c_ent_w'(j);
         end
      end
   end

   // Oldest valid entry whose address matches the returning read
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_hit_age = '0;
      for (int j = 0; j < max_out_p; j++) begin
         if (r_ent_v[j] && (r_ent_addr[j] == read_done_ch_addr_i) &&
             (!w_hit || (r_ent_age[j] > w_hit_age))) begin
            w_hit     = 1'b1;
            w_hit_idx = c_ent_w'(j);
            w_hit_age = r_ent_age[j];
         end
      end
   end

   assign w_ret   = reset_n_i & data_v_i;
   assign w_free  = w_ret & w_hit;
   assign error_o = w_ret & ~w_hit;
   assign data_o  = data_i;
   assign outstanding_o = r_count;

   // Return strobe to the owner of the selected entry
   always_comb begin
      data_v_o = '0;
      if (w_free) begin
         data_v_o[r_ent_owner[w_hit_idx]] = 1'b1;
      end
   end

   // Grant FSM, round-robin pointer, tracking table and occupancy count
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state    <= c_st_idle;
         r_rr_ptr   <= '0;
         r_hold_idx <= '0;
         r_ent_v    <= '0;
         r_count    <= '0;
      end else begin
         if (w_accept) begin
            r_state  <= c_st_idle;
            r_rr_ptr <= w_rr_next;
         end else if ((r_state == c_st_idle) && w_any_elig) begin
            r_state    <= c_st_hold;
            r_hold_idx <= w_win_idx;
         end

         for (int j = 0; j < max_out_p; j++) begin
            if (w_alloc && (w_free_idx == c_ent_w'(j))) begin
               r_ent_v[j]     <= 1'b1;
               r_ent_addr[j]  <= ch_addr_o;
               r_ent_owner[j] <= w_grant;
               r_ent_age[j]   <= '0;
            end else if (w_free && (w_hit_idx == c_ent_w'(j))) begin
               r_ent_v[j] <= 1'b0;
            end else if (r_ent_v[j]) begin
               // Survivors age by one per allocation and close the gap left
               // by a freed older-than-them... younger-than-them entry
               r_ent_age[j] <= r_ent_age[j] + c_ent_w'(w_alloc)
                             - c_ent_w'(w_free && (r_ent_age[j] > w_hit_age));
            end
         end

         r_count <= r_count + c_cnt_w'(w_alloc) - c_cnt_w'(w_free);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bsg_dramsim3_ch_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bsg_dramsim3_ch_arbiter
// Brief    : Scenario bench for the dramsim3 channel arbiter; expected grant
//            and return strobes are queued as stimulus is applied.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_dramsim3_ch_arbiter;

   localparam int c_nr = 2;
   localparam int c_aw = 32;
   localparam int c_dw = 256;
   localparam int c_mo = 8;

   logic                          clk_i = 1'b0;
   logic                          reset_n_i;
   logic [c_nr-1:0]               v_i;
   logic [c_nr-1:0]               write_not_read_i;
   logic [c_nr-1:0][c_aw-1:0]     ch_addr_i;
   logic [c_nr-1:0]               yumi_o;
   logic                          v_o;
   logic                          write_not_read_o;
   logic [c_aw-1:0]               ch_addr_o;
   logic                          yumi_i;
   logic                          data_v_i;
   logic [c_aw-1:0]               read_done_ch_addr_i;
   logic [c_dw-1:0]               data_i;
   logic [c_nr-1:0]               data_v_o;
   logic [c_dw-1:0]               data_o;
   logic [$clog2(c_mo):0]         outstanding_o;
   logic                          error_o;

   int checks = 0;
   int errors = 0;

   logic [1:0]      exp_yumi_q [$];
   logic [c_aw-1:0] exp_addr_q [$];
   logic [1:0]      exp_dv_q   [$];

   always #5 clk_i = ~clk_i;

   bsg_dramsim3_ch_arbiter #(
      .num_req_p(c_nr), .channel_addr_width_p(c_aw),
      .data_width_p(c_dw), .max_out_p(c_mo)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i),
      .write_not_read_i(write_not_read_i), .ch_addr_i(ch_addr_i),
      .yumi_o(yumi_o), .v_o(v_o), .write_not_read_o(write_not_read_o),
      .ch_addr_o(ch_addr_o), .yumi_i(yumi_i), .data_v_i(data_v_i),
      .read_done_ch_addr_i(read_done_ch_addr_i), .data_i(data_i),
      .data_v_o(data_v_o), .data_o(data_o), .outstanding_o(outstanding_o),
      .error_o(error_o)
   );

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      v_i = '0;
      write_not_read_i = '0;
      yumi_i = 1'b0;
      data_v_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0;
      v_i = 2'b11; write_not_read_i = 2'b00; yumi_i = 1'b1;
      ch_addr_i[0] = 32'h10; ch_addr_i[1] = 32'h20;
      data_v_i = 1'b1; read_done_ch_addr_i = 32'h300; data_i = '0;
      tick(); tick();
      @(negedge clk_i);
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
      checks++; if (yumi_o !== 2'b00) begin errors++; $display("FAIL reset_yumi_o: got %b want 00", yumi_o); end
      checks++; if (data_v_o !== 2'b00) begin errors++; $display("FAIL reset_data_v_o: got %b want 00", data_v_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error_o: got %b want 0", error_o); end
      checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
      tick();
      reset_n_i = 1'b1;
      idle_inputs();
   endtask

   task automatic test_fairness();
      logic [1:0] e;
      logic [c_aw-1:0] a;
      v_i = 2'b11; write_not_read_i = 2'b00; yumi_i = 1'b1;
      ch_addr_i[0] = 32'h10; ch_addr_i[1] = 32'h20;
      for (int i = 0; i < 4; i++) begin
         exp_yumi_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
         exp_addr_q.push_back((i % 2 == 0) ? 32'h10 : 32'h20);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         e = exp_yumi_q.pop_front();
         a = exp_addr_q.pop_front();
         checks++; if (yumi_o !== e) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", i, yumi_o, e); end
         checks++; if (ch_addr_o !== a) begin errors++; $display("FAIL fair_addr[%0d]: got %h want %h", i, ch_addr_o, a); end
         tick();
      end
      idle_inputs();
      // Drain: 0x20 belongs to requester 1, 0x10 to requester 0
      for (int i = 0; i < 4; i++) exp_dv_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
      for (int i = 0; i < 4; i++) begin
         data_v_i = 1'b1;
         read_done_ch_addr_i = (i % 2 == 0) ? 32'h20 : 32'h10;
         @(negedge clk_i);
         e = exp_dv_q.pop_front();
         checks++; if (data_v_o !== e) begin errors++; $display("FAIL fair_ret[%0d]: got %b want %b", i, data_v_o, e); end
         checks++; if (outstanding_o !== 4'(4 - i)) begin errors++; $display("FAIL fair_count[%0d]: got %0d want %0d", i, outstanding_o, 4 - i); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_hold();
      logic [1:0] e;
      // A write grant to requester 0 moves the pointer to requester 1
      v_i = 2'b01; write_not_read_i = 2'b01; ch_addr_i[0] = 32'h1; yumi_i = 1'b1;
      @(negedge clk_i);
      checks++; if (yumi_o !== 2'b01) begin errors++; $display("FAIL hold_pre_write: got %b want 01", yumi_o); end
      tick();
      v_i = 2'b01; write_not_read_i = 2'b00; ch_addr_i[0] = 32'h40; yumi_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checks++; if (v_o !== 1'b1 || ch_addr_o !== 32'h40 || yumi_o !== 2'b00) begin
            errors++; $display("FAIL hold_stall[%0d]: got v=%b addr=%h yumi=%b want v=1 addr=40 yumi=00", i, v_o, ch_addr_o, yumi_o);
         end
         tick();
         v_i = 2'b11; ch_addr_i[1] = 32'h99;
      end
      yumi_i = 1'b1;
      exp_yumi_q.push_back(2'b01); exp_addr_q.push_back(32'h40);
      exp_yumi_q.push_back(2'b10); exp_addr_q.push_back(32'h99);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         e = exp_yumi_q.pop_front();
         checks++; if (yumi_o !== e || ch_addr_o !== exp_addr_q[0]) begin
            errors++; $display("FAIL hold_grant[%0d]: got yumi=%b addr=%h want yumi=%b addr=%h", i, yumi_o, ch_addr_o, e, exp_addr_q[0]);
         end
         void'(exp_addr_q.pop_front());
         tick();
         v_i = 2'b10;
      end
      idle_inputs();
      exp_dv_q.push_back(2'b01); exp_dv_q.push_back(2'b10);
      for (int i = 0; i < 2; i++) begin
         data_v_i = 1'b1; read_done_ch_addr_i = (i == 0) ? 32'h40 : 32'h99;
         @(negedge clk_i);
         e = exp_dv_q.pop_front();
         checks++; if (data_v_o !== e) begin errors++; $display("FAIL hold_ret[%0d]: got %b want %b", i, data_v_o, e); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_full();
      logic [1:0] e;
      v_i = 2'b01; write_not_read_i = 2'b00; yumi_i = 1'b1;
      for (int i = 0; i < c_mo; i++) begin
         ch_addr_i[0] = 32'h1000 + 32'(i);
         @(negedge clk_i);
         checks++; if (yumi_o !== 2'b01) begin errors++; $display("FAIL full_fill[%0d]: got %b want 01", i, yumi_o); end
         tick();
      end
      ch_addr_i[0] = 32'h2000;
      @(negedge clk_i);
      checks++; if (v_o !== 1'b0 || yumi_o !== 2'b00 || outstanding_o !== 4'd8) begin
         errors++; $display("FAIL full_block: got v=%b yumi=%b cnt=%0d want v=0 yumi=00 cnt=8", v_o, yumi_o, outstanding_o);
      end
      tick();
      v_i = 2'b11; write_not_read_i = 2'b10; ch_addr_i[1] = 32'h3000;
      @(negedge clk_i);
      checks++; if (yumi_o !== 2'b10 || write_not_read_o !== 1'b1 || ch_addr_o !== 32'h3000) begin
         errors++; $display("FAIL full_write: got yumi=%b wnr=%b addr=%h want yumi=10 wnr=1 addr=3000", yumi_o, write_not_read_o, ch_addr_o);
      end
      tick();
      // Return while full: the read stays blocked this cycle
      v_i = 2'b01; write_not_read_i = 2'b00; data_v_i = 1'b1; read_done_ch_addr_i = 32'h1000;
      @(negedge clk_i);
      checks++; if (v_o !== 1'b0 || data_v_o !== 2'b01 || outstanding_o !== 4'd8) begin
         errors++; $display("FAIL full_free_same_cycle: got v=%b dv=%b cnt=%0d want v=0 dv=01 cnt=8", v_o, data_v_o, outstanding_o);
      end
      tick();
      data_v_i = 1'b0;
      @(negedge clk_i);
      checks++; if (yumi_o !== 2'b01 || ch_addr_o !== 32'h2000 || outstanding_o !== 4'd7) begin
         errors++; $display("FAIL full_unblock: got yumi=%b addr=%h cnt=%0d want yumi=01 addr=2000 cnt=7", yumi_o, ch_addr_o, outstanding_o);
      end
      tick();
      idle_inputs();
      for (int i = 0; i < c_mo; i++) exp_dv_q.push_back(2'b01);
      for (int i = 0; i < c_mo; i++) begin
         data_v_i = 1'b1;
         read_done_ch_addr_i = (i < 7) ? 32'h1001 + 32'(i) : 32'h2000;
         @(negedge clk_i);
         e = exp_dv_q.pop_front();
         checks++; if (data_v_o !== e || outstanding_o !== 4'(8 - i)) begin
            errors++; $display("FAIL full_drain[%0d]: got dv=%b cnt=%0d want dv=%b cnt=%0d", i, data_v_o, outstanding_o, e, 8 - i);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_out_of_order();
      v_i = 2'b01; ch_addr_i[0] = 32'h100; yumi_i = 1'b1;
      tick();
      v_i = 2'b10; ch_addr_i[1] = 32'h200;
      tick();
      idle_inputs();
      exp_dv_q.push_back(2'b10); exp_dv_q.push_back(2'b01);
      for (int i = 0; i < 2; i++) begin
         data_v_i = 1'b1; read_done_ch_addr_i = (i == 0) ? 32'h200 : 32'h100;
         @(negedge clk_i);
         checks++; if (data_v_o !== exp_dv_q[0] || outstanding_o !== 4'(2 - i)) begin
            errors++; $display("FAIL ooo_ret[%0d]: got dv=%b cnt=%0d want dv=%b cnt=%0d", i, data_v_o, outstanding_o, exp_dv_q[0], 2 - i);
         end
         void'(exp_dv_q.pop_front());
         tick();
      end
      idle_inputs();
      @(negedge clk_i);
      checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL ooo_empty: got %0d want 0", outstanding_o); end
      tick();
      // Allocate and free in the same cycle leaves the count unchanged
      v_i = 2'b01; ch_addr_i[0] = 32'h100; yumi_i = 1'b1;
      tick();
      v_i = 2'b10; ch_addr_i[1] = 32'h200; data_v_i = 1'b1; read_done_ch_addr_i = 32'h100;
      @(negedge clk_i);
      checks++; if (data_v_o !== 2'b01 || yumi_o !== 2'b10) begin
         errors++; $display("FAIL ooo_alloc_free: got dv=%b yumi=%b want dv=01 yumi=10", data_v_o, yumi_o);
      end
      tick();
      idle_inputs();
      data_v_i = 1'b1; read_done_ch_addr_i = 32'h200;
      @(negedge clk_i);
      checks++; if (outstanding_o !== 4'd1 || data_v_o !== 2'b10) begin
         errors++; $display("FAIL ooo_after_swap: got cnt=%0d dv=%b want cnt=1 dv=10", outstanding_o, data_v_o);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_same_addr();
      // Requester 1 then 0 read the same address; returns follow issue order
      yumi_i = 1'b1; ch_addr_i[0] = 32'h80; ch_addr_i[1] = 32'h80;
      v_i = 2'b10; tick();
      v_i = 2'b01; tick();
      idle_inputs();
      exp_dv_q.push_back(2'b10); exp_dv_q.push_back(2'b01);
      for (int i = 0; i < 2; i++) begin
         data_v_i = 1'b1; read_done_ch_addr_i = 32'h80;
         @(negedge clk_i);
         checks++; if (data_v_o !== exp_dv_q[0]) begin
            errors++; $display("FAIL same_ret[%0d]: got %b want %b", i, data_v_o, exp_dv_q[0]);
         end
         void'(exp_dv_q.pop_front());
         tick();
      end
      idle_inputs();
      // A hole refilled by a younger read must not jump the queue
      yumi_i = 1'b1;
      v_i = 2'b01; ch_addr_i[0] = 32'h80; tick();
      v_i = 2'b10; ch_addr_i[1] = 32'h90; tick();
      v_i = 2'b10; ch_addr_i[1] = 32'h80; tick();
      idle_inputs();
      data_v_i = 1'b1; read_done_ch_addr_i = 32'h90; tick();
      data_v_i = 1'b0; yumi_i = 1'b1; v_i = 2'b01; ch_addr_i[0] = 32'h80; tick();
      idle_inputs();
      exp_dv_q.push_back(2'b01); exp_dv_q.push_back(2'b10); exp_dv_q.push_back(2'b01);
      for (int i = 0; i < 3; i++) begin
         data_v_i = 1'b1; read_done_ch_addr_i = 32'h80;
         @(negedge clk_i);
         checks++; if (data_v_o !== exp_dv_q[0]) begin
            errors++; $display("FAIL age_ret[%0d]: got %b want %b", i, data_v_o, exp_dv_q[0]);
         end
         void'(exp_dv_q.pop_front());
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_error_reset();
      logic [c_dw-1:0] pat;
      pat = {8{32'hCAFE_F00D}};
      data_i = pat;
      data_v_i = 1'b1; read_done_ch_addr_i = 32'h300;
      @(negedge clk_i);
      checks++; if (error_o !== 1'b1 || data_v_o !== 2'b00) begin
         errors++; $display("FAIL err_pulse: got err=%b dv=%b want err=1 dv=00", error_o, data_v_o);
      end
      checks++; if (data_o !== pat) begin errors++; $display("FAIL data_fwd: got %h want %h", data_o, pat); end
      tick();
      data_v_i = 1'b0;
      @(negedge clk_i);
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", error_o); end
      tick();
      yumi_i = 1'b1;
      v_i = 2'b01; ch_addr_i[0] = 32'h500; tick();
      v_i = 2'b10; ch_addr_i[1] = 32'h600; tick();
      v_i = 2'b01; ch_addr_i[0] = 32'h700; tick();
      v_i = 2'b10; ch_addr_i[1] = 32'h800; yumi_i = 1'b0;
      @(negedge clk_i);
      checks++; if (outstanding_o !== 4'd3 || v_o !== 1'b1) begin
         errors++; $display("FAIL err_setup: got cnt=%0d v=%b want cnt=3 v=1", outstanding_o, v_o);
      end
      tick();
      reset_n_i = 1'b0; yumi_i = 1'b1;
      @(negedge clk_i);
      checks++; if (v_o !== 1'b0 || yumi_o !== 2'b00) begin
         errors++; $display("FAIL rst_mid_out: got v=%b yumi=%b want v=0 yumi=00", v_o, yumi_o);
      end
      tick();
      reset_n_i = 1'b1; yumi_i = 1'b1;
      v_i = 2'b01; write_not_read_i = 2'b01; ch_addr_i[0] = 32'h900;
      @(negedge clk_i);
      checks++; if (outstanding_o !== 4'd0 || ch_addr_o !== 32'h900) begin
         errors++; $display("FAIL rst_cleared: got cnt=%0d addr=%h want cnt=0 addr=900", outstanding_o, ch_addr_o);
      end
      tick();
      idle_inputs();
      data_v_i = 1'b1; read_done_ch_addr_i = 32'h500;
      @(negedge clk_i);
      checks++; if (error_o !== 1'b1 || data_v_o !== 2'b00) begin
         errors++; $display("FAIL rst_stale_ret: got err=%b dv=%b want err=1 dv=00", error_o, data_v_o);
      end
      tick();
      idle_inputs();
   endtask

   // Bound on total run time
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200us");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_fairness();
      test_hold();
      test_full();
      test_out_of_order();
      test_same_addr();
      test_error_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
